load_store_unit: RTL and testbench

- Parametrised data-memory access unit that replaces the datapath's inline doubleword-only memory read/write.
- Supports byte, half, word and double accesses with little-endian lane selection.
- Sign- or zero-extends loads; merges partial stores into the addressed doubleword.
- Adds a valid/ready request/response handshake, configurable access latency, and misalignment/range error reporting.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// Data-memory access unit. It takes one request at a time over a valid/ready
// handshake, waits LATENCY cycles, performs a byte/half/word/double load or
// store on an internal XLEN-wide memory and returns one response over a second
// valid/ready handshake. Lane selection is little-endian. Loads are sign- or
// zero-extended. Stores write only the addressed byte lanes. Misaligned and
// out-of-range accesses leave memory untouched and return an error code.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   req_valid     request present            req_ready   unit is idle
//   req_write     1 = store, 0 = load        req_size    00 B, 01 H, 10 W, 11 D
//   req_unsigned  zero-extend a load         req_addr    byte address
//   req_wdata     store data, low-order bits
//   resp_valid    response present           resp_ready  consumer accepts
//   resp_rdata    load result (0 for stores and errors)
//   resp_err      access rejected            err_code    01 misaligned, 10 range
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      err_code
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int IDXW   = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic              write_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic              resp_err_reg;
    logic [1:0]        err_code_reg;

    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   rd_reg;

    logic [OFFW-1:0]   offset;
    logic [OFFW+2:0]   lane_shift;
    logic [IDXW-1:0]   rd_idx;
    logic [IDXW-1:0]   wr_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              access_err;
    logic [1:0]        access_code;
    logic [OFFW:0]     size_bytes;
    logic [NBYTES-1:0] byte_en;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rdata_sh;
    logic [XLEN-1:0]   load_val;
    logic              sext;
    logic              do_store;

    assign offset     = addr_reg[OFFW-1:0];
    assign lane_shift = {offset, 3'b000};
    assign wr_idx     = addr_reg[OFFW +: IDXW];
    // The RAM read is registered, so the address is taken straight from the
    // request port while idle; the word is then ready by the ACCESS cycle even
    // when there are no wait cycles.
    assign rd_idx     = (state_reg == S_IDLE) ? req_addr[OFFW +: IDXW] : wr_idx;

    always_comb begin
        misaligned = 1'b0;
        size_bytes = (OFFW + 1)'(NBYTES);
        case (size_reg)
            2'b00: size_bytes = (OFFW + 1)'(1);
            2'b01: begin
                misaligned = addr_reg[0];
                size_bytes = (OFFW + 1)'(2);
            end
            2'b10: begin
                misaligned = |addr_reg[1:0];
                size_bytes = (OFFW + 1)'(4);
            end
            default: misaligned = |addr_reg[OFFW-1:0];
        endcase
    end

    // Full-width compare so that high address bits never alias into range.
    assign out_of_range = (addr_reg >> OFFW) >= XLEN'(DEPTH);
    assign access_err   = misaligned | out_of_range;
    assign access_code  = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);

    // A lane is enabled when it lies in [offset, offset + size_bytes).
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign byte_en[gi] = ((OFFW + 1)'(gi) >= {1'b0, offset}) &&
                                 ((OFFW + 1)'(gi) < ({1'b0, offset} + size_bytes));
        end
    endgenerate

    assign wdata_sh = wdata_reg << lane_shift;
    assign rdata_sh = rd_reg >> lane_shift;
    assign sext     = ~unsigned_reg;
    assign do_store = (state_reg == S_ACCESS) && write_reg && !access_err;

    always_comb begin
        case (size_reg)
            2'b00:   load_val = {{(XLEN-8){sext & rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_val = {{(XLEN-16){sext & rdata_sh[15]}}, rdata_sh[15:0]};
            2'b10:   load_val = {{(XLEN-32){sext & rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_val = rd_reg;
        endcase
    end

    // Memory: byte-enabled write, registered read. Not reset.
    always_ff @(posedge clock) begin
        if (do_store) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
        rd_reg <= mem[rd_idx];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 3'd0;
            write_reg      <= 1'b0;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            err_code_reg   <= 2'b00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        write_reg     <= req_write;
                        size_reg      <= req_size;
                        unsigned_reg  <= req_unsigned;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        cnt_reg       <= CNT_INIT;
                        req_ready_reg <= 1'b0;
                        state_reg     <= (LATENCY == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg <= S_ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                S_ACCESS: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= access_err;
                    err_code_reg   <= access_code;
                    resp_rdata_reg <= (access_err || write_reg) ? '0 : load_val;
                    state_reg      <= S_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// ---------------------------------------------------------------------------
// Three instances of load_store_unit (LATENCY 0, 1 and 7) exercised with
// directed requests. A byte-addressed reference memory predicts every
// response; a per-cycle compare process checks handshake signals and response
// contents of all instances, and the directed sequence adds literal values.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 1024;
    localparam int NI    = 3;
    localparam int LATS    [NI] = '{0, 1, 7};
    localparam int EXP_LAT [NI] = '{1, 2, 8};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic            req_valid_a    [NI];
    logic            req_ready_a    [NI];
    logic            req_write_a    [NI];
    logic [1:0]      req_size_a     [NI];
    logic            req_unsigned_a [NI];
    logic [XLEN-1:0] req_addr_a     [NI];
    logic [XLEN-1:0] req_wdata_a    [NI];
    logic            resp_valid_a   [NI];
    logic            resp_ready_a   [NI];
    logic [XLEN-1:0] resp_rdata_a   [NI];
    logic            resp_err_a     [NI];
    logic [1:0]      err_code_a     [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            load_store_unit #(
                .XLEN(XLEN),
                .DEPTH(DEPTH),
                .LATENCY(LATS[gi])
            ) u_dut (
                .clock        (clock),
                .reset        (reset),
                .req_valid    (req_valid_a[gi]),
                .req_ready    (req_ready_a[gi]),
                .req_write    (req_write_a[gi]),
                .req_size     (req_size_a[gi]),
                .req_unsigned (req_unsigned_a[gi]),
                .req_addr     (req_addr_a[gi]),
                .req_wdata    (req_wdata_a[gi]),
                .resp_valid   (resp_valid_a[gi]),
                .resp_ready   (resp_ready_a[gi]),
                .resp_rdata   (resp_rdata_a[gi]),
                .resp_err     (resp_err_a[gi]),
                .err_code     (err_code_a[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference state
    bit              busy   [NI];
    int              acc    [NI];
    logic [XLEN-1:0] exp_rd [NI];
    logic            exp_er [NI];
    logic [1:0]      exp_ec [NI];
    logic [7:0]      mb     [NI][8*DEPTH];

    task automatic chk64(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst %0d cyc %0d got %h exp %h", nm, k, cyc, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [1:0] model_code(input logic [1:0] sz, input logic [63:0] a);
        int n = nbytes(sz);
        if ((a & 64'(n - 1)) != 64'd0) return 2'b01;
        if ((a / 64'd8) >= 64'(DEPTH)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [63:0] model_load(input int k, input logic [1:0] sz, input logic un, input logic [63:0] a);
        int n = nbytes(sz);
        int base = int'(a[12:0]);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mb[k][base + i]) << (8 * i));
        if (!un && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input int k, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int base = int'(a[12:0]);
        for (int i = 0; i < nbytes(sz); i++) mb[k][base + i] = wd[8*i +: 8];
    endtask

    // Per-cycle compare of every instance against the reference timing/data.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                bit ev;
                ev = busy[k] && (cyc >= acc[k] + 1 + LATS[k]);
                chk64("req_ready", k, 64'(req_ready_a[k]), 64'(!busy[k]));
                chk64("resp_valid", k, 64'(resp_valid_a[k]), 64'(ev));
                if (ev) begin
                    chk64("resp_rdata", k, resp_rdata_a[k], exp_rd[k]);
                    chk64("resp_err", k, 64'(resp_err_a[k]), 64'(exp_er[k]));
                    chk64("err_code", k, 64'(err_code_a[k]), 64'(exp_ec[k]));
                end
            end
        end
    end

    task automatic drive_req(input int k, input logic wr, input logic [1:0] sz, input logic un,
                             input logic [63:0] a, input logic [63:0] wd);
        @(negedge clock);
        req_write_a[k]    = wr;
        req_size_a[k]     = sz;
        req_unsigned_a[k] = un;
        req_addr_a[k]     = a;
        req_wdata_a[k]    = wd;
        req_valid_a[k]    = 1'b1;
        @(posedge clock);
        #1;
        busy[k]   = 1'b1;
        acc[k]    = cyc;
        exp_ec[k] = model_code(sz, a);
        exp_er[k] = (exp_ec[k] != 2'b00);
        exp_rd[k] = (wr || exp_er[k]) ? 64'd0 : model_load(k, sz, un, a);
        // Change every field after acceptance; the captured request must not follow.
        req_valid_a[k]    = 1'b0;
        req_write_a[k]    = ~wr;
        req_size_a[k]     = ~sz;
        req_unsigned_a[k] = ~un;
        req_addr_a[k]     = ~a;
        req_wdata_a[k]    = ~wd;
    endtask

    // One full transaction plus literal checks of its result and latency.
    task automatic op(input int k, input string nm, input logic wr, input logic [1:0] sz, input logic un,
                      input logic [63:0] a, input logic [63:0] wd, input logic [63:0] x_rd,
                      input logic [1:0] x_ec, input int hold, input bit inject);
        int lat_obs;
        logic [63:0] rd;
        logic er;
        logic [1:0] ec;
        drive_req(k, wr, sz, un, a, wd);
        lat_obs = 0;
        while (resp_valid_a[k] !== 1'b1 && lat_obs < 20) begin
            @(posedge clock);
            #1;
            lat_obs++;
        end
        if (wr && !exp_er[k]) model_store(k, sz, a, wd);
        rd = resp_rdata_a[k];
        er = resp_err_a[k];
        ec = err_code_a[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1;
            if (inject && h == 1) begin
                req_write_a[k] = 1'b1;
                req_size_a[k]  = 2'b11;
                req_addr_a[k]  = 64'h10;
                req_wdata_a[k] = 64'd0;
                req_valid_a[k] = 1'b1;
            end
            if (inject && h == 2) req_valid_a[k] = 1'b0;
        end
        resp_ready_a[k] = 1'b1;
        @(posedge clock);
        #1;
        busy[k] = 1'b0;
        resp_ready_a[k] = 1'b0;
        chk64({nm, " latency"}, k, 64'(lat_obs), 64'(EXP_LAT[k]));
        chk64({nm, " rdata"}, k, rd, x_rd);
        chk64({nm, " err"}, k, 64'(er), 64'(x_ec != 2'b00));
        chk64({nm, " code"}, k, 64'(ec), 64'(x_ec));
    endtask

    task automatic check_reset_outputs(input string nm, input int k);
        chk64({nm, " req_ready"}, k, 64'(req_ready_a[k]), 64'd1);
        chk64({nm, " resp_valid"}, k, 64'(resp_valid_a[k]), 64'd0);
        chk64({nm, " resp_rdata"}, k, resp_rdata_a[k], 64'd0);
        chk64({nm, " resp_err"}, k, 64'(resp_err_a[k]), 64'd0);
        chk64({nm, " err_code"}, k, 64'(err_code_a[k]), 64'd0);
    endtask

    // Store interrupted by reset while waiting; the store must not land.
    task automatic reset_during_store(input int k, input logic [63:0] a, input logic [63:0] wd);
        drive_req(k, 1'b1, 2'b00, 1'b0, a, wd);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        busy[k] = 1'b0;
        #1;
        check_reset_outputs("async_reset", k);
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic run_basic(input int k);
        op(k, "st_d",   1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, 64'd0, 2'b00, 0, 1'b0);
        op(k, "ld_d",   1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 2'b00, 0, 1'b0);
        op(k, "st_b",   1'b1, 2'b00, 1'b0, 64'h13, 64'hDEADBEEFCAFE12AB, 64'd0, 2'b00, 0, 1'b0);
        op(k, "ld_d2",  1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h11223344AB667788, 2'b00, 0, 1'b0);
        op(k, "ld_bs",  1'b0, 2'b00, 1'b0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFFAB, 2'b00, 0, 1'b0);
        op(k, "ld_bu",  1'b0, 2'b00, 1'b1, 64'h13, 64'd0, 64'h00000000000000AB, 2'b00, 0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid_a[k] = 1'b0;
            req_write_a[k] = 1'b0;
            req_size_a[k] = 2'b00;
            req_unsigned_a[k] = 1'b0;
            req_addr_a[k] = 64'd0;
            req_wdata_a[k] = 64'd0;
            resp_ready_a[k] = 1'b0;
            busy[k] = 1'b0;
            acc[k] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < NI; k++) check_reset_outputs("reset", k);
        @(negedge clock);
        reset = 1'b1;
        chk_en = 1'b1;

        for (int k = 0; k < NI; k++) run_basic(k);

        // Error handling and further lane/extension cases on LATENCY=1
        op(1, "ld_w_mis",  1'b0, 2'b10, 1'b0, 64'h12, 64'd0, 64'd0, 2'b01, 0, 1'b0);
        op(1, "ld_d_keep", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h11223344AB667788, 2'b00, 0, 1'b0);
        op(1, "ld_d_oor",  1'b0, 2'b11, 1'b0, 64'h2000, 64'd0, 64'd0, 2'b10, 0, 1'b0);
        op(1, "ld_h_both", 1'b0, 2'b01, 1'b0, 64'h2001, 64'd0, 64'd0, 2'b01, 0, 1'b0);
        op(1, "ld_d_high", 1'b0, 2'b11, 1'b0, 64'h8000000000000010, 64'd0, 64'd0, 2'b10, 0, 1'b0);
        op(1, "st_w_mis",  1'b1, 2'b10, 1'b0, 64'h12, 64'hFFFFFFFF, 64'd0, 2'b01, 0, 1'b0);
        op(1, "st_d_oor",  1'b1, 2'b11, 1'b0, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 2'b10, 0, 1'b0);
        op(1, "ld_d_same", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h11223344AB667788, 2'b00, 0, 1'b0);
        op(1, "st_h",      1'b1, 2'b01, 1'b0, 64'h16, 64'h8001, 64'd0, 2'b00, 0, 1'b0);
        op(1, "ld_hs",     1'b0, 2'b01, 1'b0, 64'h16, 64'd0, 64'hFFFFFFFFFFFF8001, 2'b00, 0, 1'b0);
        op(1, "ld_wu",     1'b0, 2'b10, 1'b1, 64'h14, 64'd0, 64'h0000000080013344, 2'b00, 0, 1'b0);
        op(1, "ld_ws",     1'b0, 2'b10, 1'b0, 64'h14, 64'd0, 64'hFFFFFFFF80013344, 2'b00, 0, 1'b0);
        op(1, "ld_hu",     1'b0, 2'b01, 1'b1, 64'h10, 64'd0, 64'h0000000000007788, 2'b00, 0, 1'b0);

        // Back-pressure with a stray request that must be dropped
        op(1, "ld_hold",   1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h80013344AB667788, 2'b00, 5, 1'b1);
        op(1, "ld_after",  1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h80013344AB667788, 2'b00, 0, 1'b0);

        // Reset during a pending store on LATENCY=7
        op(2, "st_d20",    1'b1, 2'b11, 1'b0, 64'h20, 64'h0123456789ABCDEF, 64'd0, 2'b00, 0, 1'b0);
        reset_during_store(2, 64'h20, 64'hFF);
        op(2, "ld_d20",    1'b0, 2'b11, 1'b0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 2'b00, 0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d got timeout exp completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
